// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Resolves EX-stage control-flow instructions against the PC already in ID.
// On a mismatch (or an empty ID slot) it flags a mispredict, issues a
// registered redirect to fetch over a valid/ready handshake, and then keeps
// squash asserted for FLUSH_DEPTH cycles after the redirect is accepted.
// It also keeps saturating performance counters.
//
// Ports
//   clk, rst_b              core clock, async active-low reset
//   stall_in                EX instruction does not resolve this cycle
//   ex_valid/ex_ctrl/ex_sel EX instruction qualifiers and next-PC select
//   pc_ex, pc_id, id_valid  EX PC, PC sitting in ID, ID occupancy
//   br/jr/j_target          candidate targets
//   redirect_ready          fetch accepts the redirect
//   perf_clr                synchronous clear of both counters
//   ex_en                   EX/MEM register enable (combinational)
//   mispredict              mismatch detected this cycle (combinational)
//   squash                  kill IF/ID contents (registered)
//   redirect_valid/_pc      redirect request to fetch (registered)
//   busy                    controller not idle
//   ctrl_cnt, mispred_cnt   saturating event counters
module branch_resolve_ctrl #(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 1,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              stall_in,
  input  logic              ex_valid,
  input  logic              ex_ctrl,
  input  logic [1:0]        ex_sel,
  input  logic [XLEN-1:0]   pc_ex,
  input  logic [XLEN-1:0]   pc_id,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   br_target,
  input  logic [XLEN-1:0]   jr_target,
  input  logic [XLEN-1:0]   j_target,
  input  logic              redirect_ready,
  input  logic              perf_clr,
  output logic              ex_en,
  output logic              mispredict,
  output logic              squash,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy,
  output logic [PERF_W-1:0] ctrl_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_INIT = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [PERF_W-1:0] PERF_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic [XLEN-1:0]  target;
  logic             resolve;

  always_comb begin
    target = pc_ex + XLEN'(4);
    case (ex_sel)
      2'b01:   target = br_target;
      2'b10:   target = jr_target;
      2'b11:   target = j_target;
      default: target = pc_ex + XLEN'(4);
    endcase
  end

  assign resolve    = (state == IDLE) && ex_valid && ex_ctrl && !stall_in;
  // Gated by rst_b so the pipeline sees a clean "no mispredict, advance"
  // while reset is held, whatever the EX inputs are doing.
  assign mispredict = rst_b && resolve && (!id_valid || (pc_id != target));
  assign ex_en      = !rst_b || !(stall_in || mispredict);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      squash         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state          <= REDIRECT;
            redirect_pc    <= target;
            redirect_valid <= 1'b1;
            squash         <= 1'b1;
          end
        end
        REDIRECT: begin
          // redirect_valid is always 1 here, so ready alone completes it
          if (redirect_ready) begin
            state          <= DRAIN;
            redirect_valid <= 1'b0;
            drain_cnt      <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          // Counts FLUSH_DEPTH-1 .. 0, one squash cycle per value
          if (drain_cnt == '0) begin
            state  <= IDLE;
            squash <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          squash         <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle event; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_cnt    <= '0;
      mispred_cnt <= '0;
    end else if (perf_clr) begin
      ctrl_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && ctrl_cnt != PERF_MAX)
        ctrl_cnt <= ctrl_cnt + 1'b1;
      if (mispredict && mispred_cnt != PERF_MAX)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  localparam int XLEN = 32;
  localparam int FD   = 2;
  localparam int PW   = 6;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic stall_in, ex_valid, ex_ctrl, id_valid, redirect_ready, perf_clr;
  logic [1:0] ex_sel;
  logic [XLEN-1:0] pc_ex, pc_id, br_target, jr_target, j_target;
  logic ex_en, mispredict, squash, redirect_valid, busy;
  logic [XLEN-1:0] redirect_pc;
  logic [PW-1:0] ctrl_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_DEPTH(FD), .PERF_W(PW)) dut (
    .clk(clk), .rst_b(rst_b), .stall_in(stall_in), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_sel(ex_sel), .pc_ex(pc_ex), .pc_id(pc_id),
    .id_valid(id_valid), .br_target(br_target), .jr_target(jr_target),
    .j_target(j_target), .redirect_ready(redirect_ready), .perf_clr(perf_clr),
    .ex_en(ex_en), .mispredict(mispredict), .squash(squash),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .ctrl_cnt(ctrl_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic ev, ec, st, idv, rr, pc;
    logic [1:0] sel;
    logic [XLEN-1:0] pe, pi, bt, jt, jjt;
  } stim_t;

  int n_chk = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  // Reference model: a redirect is either outstanding or not; after it is
  // taken, a plain count of remaining squash cycles; counters as integers.
  bit m_pending;
  int m_drain;
  int m_ctrl, m_mis;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_tgt(input stim_t s);
    case (s.sel)
      2'd0:    return s.pe + 32'd4;
      2'd1:    return s.bt;
      2'd2:    return s.jt;
      default: return s.jjt;
    endcase
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.ev = 0; s.ec = 0; s.st = 0; s.idv = 1; s.rr = 1; s.pc = 0;
    s.sel = 2'd0; s.pe = 32'h0; s.pi = 32'h4; s.bt = 0; s.jt = 0; s.jjt = 0;
    return s;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_drain = 0; m_ctrl = 0; m_mis = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check against the model, advance the model
  // to what the coming posedge should produce.
  task automatic cyc(input stim_t s);
    bit m_busy, res, mis;
    logic [XLEN-1:0] t;
    @(negedge clk);
    ex_valid = s.ev; ex_ctrl = s.ec; stall_in = s.st; id_valid = s.idv;
    ex_sel = s.sel; pc_ex = s.pe; pc_id = s.pi; br_target = s.bt;
    jr_target = s.jt; j_target = s.jjt; redirect_ready = s.rr; perf_clr = s.pc;
    #1;
    m_busy = m_pending || (m_drain > 0);
    res = !m_busy && s.ev && s.ec && !s.st;
    t = ref_tgt(s);
    mis = res && (!s.idv || s.pi != t);
    chk("mispredict", mispredict, mis);
    chk("ex_en", ex_en, !(s.st || mis));
    chk("busy", busy, m_busy);
    chk("squash", squash, m_busy);
    chk("redirect_valid", redirect_valid, m_pending);
    chk("ctrl_cnt", ctrl_cnt, m_ctrl);
    chk("mispred_cnt", mispred_cnt, m_mis);
    if (s.pc) begin
      m_ctrl = 0; m_mis = 0;
    end else begin
      if (res && m_ctrl < PMAX) m_ctrl++;
      if (mis && m_mis < PMAX) m_mis++;
    end
    if (m_pending && s.rr) begin
      m_pending = 0; m_drain = FD;
    end else if (m_drain > 0) begin
      m_drain--;
    end
    if (mis) begin
      m_pending = 1;
      exp_q.push_back(t);
    end
  endtask

  // Monitor: whenever a redirect is presented, its PC must match the oldest
  // expected redirect; it is retired when fetch accepts it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_b && redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("redirect_unexpected", redirect_valid, 1'b0);
        end else begin
          chk("redirect_pc", redirect_pc, exp_q[0]);
          if (redirect_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    ex_valid = 1; ex_ctrl = 1; stall_in = 0; id_valid = 0; ex_sel = 2'd1;
    pc_ex = 32'h100; pc_id = 32'h104; br_target = 32'h999; jr_target = 0;
    j_target = 0; redirect_ready = 1; perf_clr = 0;
    model_reset();
    #2;
    // Reset values, with a would-be mispredict on the inputs
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_squash", squash, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl_cnt", ctrl_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_ex_en", ex_en, 1);
    ex_valid = 0;
    @(negedge clk);
    rst_b = 1;

    // 1: sequential PC matches ID
    s = idle_stim(); s.ev = 1; s.ec = 1; s.pe = 32'h100; s.pi = 32'h104;
    cyc(s);
    cyc(idle_stim());
    chk("t1_ctrl_cnt", ctrl_cnt, 1);
    chk("t1_mispred_cnt", mispred_cnt, 0);

    // 2: taken branch to 0x200, fetch ready
    s = idle_stim(); s.ev = 1; s.ec = 1; s.sel = 2'd1; s.bt = 32'h200;
    s.pe = 32'h100; s.pi = 32'h104;
    cyc(s);
    cyc(idle_stim());
    chk("t2_redirect_pc", redirect_pc, 32'h200);
    for (int i = 0; i < FD + 2; i++) cyc(idle_stim());
    chk("t2_mispred_cnt", mispred_cnt, 1);

    // 3: fetch stalls 3 cycles; a second mismatching jump is ignored
    s = idle_stim(); s.ev = 1; s.ec = 1; s.sel = 2'd1; s.bt = 32'h340;
    s.pe = 32'h300; s.pi = 32'h304; s.rr = 0;
    cyc(s);
    s.sel = 2'd3; s.jjt = 32'h800;
    for (int i = 0; i < 3; i++) cyc(s);
    chk("t3_hold_pc", redirect_pc, 32'h340);
    for (int i = 0; i < FD + 2; i++) cyc(idle_stim());

    // 4: pc+4 wraps to 0; stalled mismatch does not resolve
    s = idle_stim(); s.ev = 1; s.ec = 1; s.pe = 32'hFFFF_FFFC; s.pi = 32'h0;
    cyc(s);
    s.st = 1; s.sel = 2'd2; s.jt = 32'h4444;
    cyc(s);
    cyc(idle_stim());

    // Empty ID slot always mispredicts even if the PC would match
    s = idle_stim(); s.ev = 1; s.ec = 1; s.pe = 32'h500; s.pi = 32'h504; s.idv = 0;
    cyc(s);
    for (int i = 0; i < FD + 2; i++) cyc(idle_stim());

    // 5: saturation, then clear racing a mispredict
    s = idle_stim(); s.ev = 1; s.ec = 1; s.pe = 32'h600; s.pi = 32'h604;
    for (int i = 0; i < PMAX + 6; i++) cyc(s);
    cyc(idle_stim());
    chk("t5_ctrl_sat", ctrl_cnt, PMAX);
    s = idle_stim(); s.ev = 1; s.ec = 1; s.sel = 2'd1; s.bt = 32'h700;
    s.pe = 32'h600; s.pi = 32'h604; s.pc = 1;
    cyc(s);
    cyc(idle_stim());
    chk("t5_clr_mispred", mispred_cnt, 0);
    for (int i = 0; i < FD + 2; i++) cyc(idle_stim());

    // 6: async reset while a redirect is outstanding
    s = idle_stim(); s.ev = 1; s.ec = 1; s.sel = 2'd3; s.jjt = 32'hA00;
    s.pe = 32'h900; s.pi = 32'h904; s.rr = 0;
    cyc(s);
    s.ev = 0;
    cyc(s);
    @(negedge clk);
    #3;
    rst_b = 0;
    #1;
    chk("t6_rst_redirect_valid", redirect_valid, 0);
    chk("t6_rst_squash", squash, 0);
    chk("t6_rst_busy", busy, 0);
    model_reset();
    ex_valid = 0; redirect_ready = 1;
    @(negedge clk);
    rst_b = 1;
    for (int i = 0; i < 4; i++) cyc(idle_stim());

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      s.ev  = ($urandom % 4) != 0;
      s.ec  = ($urandom % 4) != 0;
      s.st  = ($urandom % 5) == 0;
      s.idv = ($urandom % 8) != 0;
      s.rr  = ($urandom % 2) != 0;
      s.pc  = ($urandom % 25) == 0;
      s.sel = 2'($urandom % 4);
      s.pe  = $urandom & 32'hFFFF_FFFC;
      s.bt  = $urandom & 32'hFFFF_FFFC;
      s.jt  = $urandom;
      s.jjt = $urandom & 32'hFFFF_FFFC;
      s.pi  = ($urandom % 2) ? ref_tgt(s) : ($urandom & 32'hFFFF_FFFC);
      cyc(s);
    end
    for (int i = 0; i < FD + 4; i++) cyc(idle_stim());
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Parametrised branch-resolution and flush controller for the pipelined core. It sits beside the EX stage and compares the resolved next-PC of an EX-stage control-flow instruction against the PC already occupying ID. On a mismatch it raises a mispredict, issues a registered redirect to fetch via a valid/ready handshake, and squashes FLUSH_DEPTH younger cycles. It also keeps saturating performance counters for control-flow instructions and mispredicts.

Parameters:
XLEN, 32, address/PC width
FLUSH_DEPTH, 1, number of cycles squash stays asserted after redirect acceptance (>=1)
PERF_W, 16, width of each performance counter

Ports:
clk  input  1  core clock
rst_b  input  1  asynchronous active-low reset
stall_in  input  1  pipeline stall; EX instruction is not resolving this cycle
ex_valid  input  1  EX holds a real instruction
ex_ctrl  input  1  EX instruction is control-flow (branch/jump/jr)
ex_sel  input  2  resolved next-PC select: 00 pc+4, 01 branch, 10 jr, 11 jump
pc_ex  input  XLEN  PC of EX instruction
pc_id  input  XLEN  PC of ID instruction
id_valid  input  1  ID holds a real instruction
br_target  input  XLEN  branch target
jr_target  input  XLEN  forwarded rs value
j_target  input  XLEN  jump target
redirect_ready  input  1  fetch accepts redirect
perf_clr  input  1  synchronous clear of both counters
ex_en  output  1  EX/MEM pipeline register enable
mispredict  output  1  mispredict detected this cycle
squash  output  1  kill IF/ID contents
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  XLEN  corrected fetch PC
busy  output  1  controller not IDLE
ctrl_cnt  output  PERF_W  resolved control-flow instruction count
mispred_cnt  output  PERF_W  mispredict count

Behaviour:
- Reset (rst_b low, async): state IDLE. redirect_valid=0, redirect_pc=0, squash=0, busy=0, counters=0. mispredict is forced to 0 and ex_en to 1.
- Resolved target is combinational. sel 00 gives pc_ex+4 modulo 2^XLEN (wraps, no carry out). sel 01/10/11 give br/jr/j target.
- resolve = state==IDLE && ex_valid && ex_ctrl && !stall_in.
- Mispredict condition: resolve && (!id_valid || pc_id != target). An empty ID slot always counts as a mispredict.
- mispredict is combinational and asserts in the same cycle as the condition.
- ex_en is combinational: ex_en=0 when stall_in, or when mispredict is asserted; otherwise 1.
- States:
  - IDLE -> REDIRECT when mispredict. Register redirect_pc=target. redirect_valid=1 and squash=1 from the next cycle.
  - REDIRECT: hold redirect_valid, redirect_pc and squash stable until redirect_ready. On redirect_valid && redirect_ready, go to DRAIN, load cnt=FLUSH_DEPTH-1 and drop redirect_valid next cycle.
  - DRAIN: squash=1. If cnt==0 go to IDLE, else decrement. Total squash cycles after the handshake cycle equals FLUSH_DEPTH.
  - A DRAIN->IDLE exit allows detection in the very next cycle.
- In REDIRECT/DRAIN, no new detection occurs and stall_in is ignored for state progress. ex_en still follows stall_in.
- busy=1 whenever state != IDLE.
- Counters:
  - ctrl_cnt increments on resolve; mispred_cnt increments on mispredict.
  - Both saturate at 2^PERF_W-1 (no wrap).
  - perf_clr has priority over a same-cycle increment; the counter becomes 0 and the event is dropped.
- Reset mid-REDIRECT/DRAIN aborts immediately to the reset values; no redirect is re-issued.

Test Plan:
1. pc_ex=0x100, ex_sel=00, pc_id=0x104, ex_valid=ex_ctrl=id_valid=1 -> mispredict=0, ex_en=1, ctrl_cnt increments 0->1, mispred_cnt stays 0.
2. ex_sel=01, br_target=0x200, pc_id=0x104, redirect_ready=1 -> detect cycle: mispredict=1, ex_en=0. Next cycle: redirect_valid=1, redirect_pc=0x200, squash=1. Then squash for exactly FLUSH_DEPTH further cycles, then IDLE. mispred_cnt=1.
3. Same mispredict with redirect_ready held 0 for 3 cycles -> redirect_valid/redirect_pc stay stable for 3 cycles; a second mismatching branch presented meanwhile is ignored; DRAIN starts after the handshake.
4. pc_ex=0xFFFFFFFC, ex_sel=00, pc_id=0x0 -> no mispredict (wrap). Separately, a stall_in=1 mismatch -> no mispredict, ex_en=0, counters unchanged.
5. Force ctrl_cnt to 0xFFFF, resolve once more -> stays 0xFFFF. perf_clr together with a mispredict -> mispred_cnt=0.
6. Assert rst_b=0 mid-REDIRECT -> redirect_valid, squash and busy drop to 0 immediately (async). After release, state is IDLE and no redirect is issued.
